// File: rtl/poly_reduce_1305.sv
// Reduces a 258-bit product modulo p = 2^130 - 5: limb-serial first fold, one-cycle second fold, conditional subtract.
// Latency K+2 edges from accepted start to done; start is ignored while busy, with no queuing.
module poly_reduce_1305 #(
    parameter int LIMB = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [257:0] product_in,
    output logic [129:0] result_out,
    output logic         busy,
    output logic         done
);
    localparam int K  = (132 + LIMB - 1) / LIMB;
    localparam int W  = K * LIMB;
    localparam int KW = $clog2(K + 1);
    localparam logic [130:0] P = (131'd1 << 130) - 131'd5;

    typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, SUB} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    lo_sh, h5_sh, sum;
    logic            carry;
    logic [KW-1:0]   k;
    logic [130:0]    u;
    logic [LIMB:0]   limb_add;
    logic [130:0]    hi5;
    logic [3:0]      top5;
    logic            last_limb;

    assign hi5       = {1'b0, product_in[257:130], 2'b00} + {3'b000, product_in[257:130]};
    assign limb_add  = {1'b0, lo_sh[LIMB-1:0]} + {1'b0, h5_sh[LIMB-1:0]} + {{LIMB{1'b0}}, carry};
    assign top5      = {sum[131:130], 2'b00} + {2'b00, sum[131:130]};
    assign last_limb = (k == KW'(K - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FOLD1;
            FOLD1:   if (last_limb) state_nx = FOLD2;
            FOLD2:   state_nx = SUB;
            SUB:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lo_sh      <= '0;
            h5_sh      <= '0;
            sum        <= '0;
            carry      <= 1'b0;
            k          <= '0;
            u          <= '0;
            result_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo_sh <= W'(product_in[129:0]);
                        h5_sh <= W'(hi5);
                        sum   <= '0;
                        carry <= 1'b0;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                FOLD1: begin
                    // Limbs enter at the top so limb 0 lands at bit 0 after K shifts.
                    sum   <= {limb_add[LIMB-1:0], sum[W-1:LIMB]};
                    lo_sh <= lo_sh >> LIMB;
                    h5_sh <= h5_sh >> LIMB;
                    carry <= limb_add[LIMB];
                    k     <= k + 1'b1;
                end
                FOLD2: begin
                    u <= {1'b0, sum[129:0]} + {127'd0, top5};
                end
                SUB: begin
                    result_out <= (u >= P) ? 130'(u - P) : u[129:0];
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_reduce_1305.sv
// Scoreboard bench for poly_reduce_1305 at LIMB=16, 8 and 64 against a % p reference.
module tb_poly_reduce_1305;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, start_x;
    logic [257:0] product_in;
    logic [129:0] r16, r8, r64;
    logic         b16, b8, b64, d16, d8, d64;

    poly_reduce_1305 #(.LIMB(16)) u16 (.clk(clk), .reset(reset), .start(start),   .product_in(product_in), .result_out(r16), .busy(b16), .done(d16));
    poly_reduce_1305 #(.LIMB(8))  u8  (.clk(clk), .reset(reset), .start(start_x), .product_in(product_in), .result_out(r8),  .busy(b8),  .done(d8));
    poly_reduce_1305 #(.LIMB(64)) u64 (.clk(clk), .reset(reset), .start(start_x), .product_in(product_in), .result_out(r64), .busy(b64), .done(d64));

    typedef struct {
        logic [129:0] res;
        int           due;
    } sb_t;

    sb_t q16[$], q8[$], q64[$];
    int  vectors = 0, miscompares = 0, cyc = 0;
    int  nacc16 = 0, ndone16 = 0, nacc_x = 0, ndone8 = 0, ndone64 = 0;
    logic [257:0] pmod;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (d16 === 1'b1) begin
            sb_t e;
            ndone16++;
            if (q16.size() == 0) chk("dut16_spurious_done", 1, 0);
            else begin
                e = q16.pop_front();
                chk("dut16_result", r16, e.res);
                chk("dut16_latency", cyc, e.due);
                chk("dut16_fold1_carry", u16.carry, 0);
            end
        end
        if (d8 === 1'b1) begin
            sb_t e;
            ndone8++;
            if (q8.size() == 0) chk("dut8_spurious_done", 1, 0);
            else begin
                e = q8.pop_front();
                chk("dut8_result", r8, e.res);
                chk("dut8_latency", cyc, e.due);
                chk("dut8_fold1_carry", u8.carry, 0);
            end
        end
        if (d64 === 1'b1) begin
            sb_t e;
            ndone64++;
            if (q64.size() == 0) chk("dut64_spurious_done", 1, 0);
            else begin
                e = q64.pop_front();
                chk("dut64_result", r64, e.res);
                chk("dut64_latency", cyc, e.due);
                chk("dut64_fold1_carry", u64.carry, 0);
            end
        end
    end

    // Drives one start pulse; c0 is the cycle count right after the sampling edge.
    task automatic issue(input logic [257:0] p, input logic [129:0] e, input bit accept,
                         input bit all, output int c0);
        sb_t s;
        @(negedge clk);
        #1;
        product_in = p;
        start      = 1'b1;
        start_x    = all;
        @(posedge clk);
        #1;
        c0    = cyc;
        s.res = e;
        if (accept) begin
            s.due = c0 + 11; q16.push_back(s); nacc16++;
            if (all) begin
                s.due = c0 + 19; q8.push_back(s);
                s.due = c0 + 5;  q64.push_back(s);
                nacc_x++;
            end
        end
        start      = 1'b0;
        start_x    = 1'b0;
        product_in = ~p;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (b16 === 1'b0 && b8 === 1'b0 && b64 === 1'b0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    logic [257:0] one258, dp[5];
    logic [129:0] de[5];
    logic [257:0] rp;
    int           c0, c1, tmp;

    initial begin
        reset = 1'b1; start = 1'b0; start_x = 1'b0; product_in = '0;
        pmod = (258'd1 << 130) - 258'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", r16, 0);
        chk("rst_busy", b16, 0);
        chk("rst_done", d16, 0);
        #1 reset = 1'b0;

        // Abort a nonzero job mid-FOLD1; start held alongside reset must also lose.
        issue({8{32'hDEADBEEF}}, '0, 1'b0, 1'b1, tmp);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; start = 1'b1; start_x = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; start = 1'b0; start_x = 1'b0;
        @(negedge clk);
        chk("abort_busy16", b16, 0);
        chk("abort_busy8", b8, 0);
        chk("abort_busy64", b64, 0);
        chk("abort_result", r16, 0);
        chk("abort_done", d16, 0);
        repeat (25) @(posedge clk);
        issue('0, '0, 1'b1, 1'b1, tmp);
        wait_idle();

        one258 = 258'd1;
        dp[0] = (one258 << 130) - 258'd5; de[0] = 130'd0;
        dp[1] = (one258 << 130) - 258'd1; de[1] = 130'd4;
        dp[2] = (one258 << 130) + 258'd2; de[2] = 130'd7;
        dp[3] = (one258 << 130);          de[3] = 130'd5;
        dp[4] = '1;                       de[4] = (130'd1 << 128) + 130'd4;
        for (int i = 0; i < 5; i++) begin
            issue(dp[i], de[i], 1'b1, 1'b1, tmp);
            wait_idle();
        end

        // Starts while busy are dropped; a start in the done cycle is taken.
        issue(dp[1], 130'd4, 1'b1, 1'b0, c0);
        issue(dp[2], 130'd7, 1'b0, 1'b0, tmp);
        chk("hs_busy_after_accept", b16, 1);
        repeat (3) @(posedge clk);
        issue(dp[3], 130'd5, 1'b0, 1'b0, tmp);
        while (cyc < c0 + 11) begin
            @(posedge clk);
            #1;
        end
        issue(dp[4], de[4], 1'b1, 1'b0, c1);
        chk("hs_b2b_accept_edge", c1, c0 + 12);
        wait_idle();

        for (int n = 0; n < 1500; n++) begin
            rp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            if (n % 16 == 0) rp[129:0] = '1;
            issue(rp, 130'(rp % pmod), 1'b1, 1'b1, tmp);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("q16_drained", q16.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("q64_drained", q64.size(), 0);
        chk("done16_count", ndone16, nacc16);
        chk("done8_count", ndone8, nacc_x);
        chk("done64_count", ndone64, nacc_x);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
